// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 width codes, FSM state encoding
// and the default address width.
package lsu_pkg;

   localparam int unsigned LSU_ADDR_W = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRmw  = 2'd1;
   localparam logic [1:0] StResp = 2'd2;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: load-lane extraction with zero/sign extension, and
// merging of a byte or halfword store into an existing memory word.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] rd_word_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_data_o,
   output logic [31:0] merged_o
);

   logic [4:0]  shamt;
   logic [31:0] shifted;
   logic [31:0] lane_mask;
   logic [31:0] lane_data;

   assign shamt   = {offset_i, 3'b000};
   assign shifted = rd_word_i >> shamt;

   always_comb begin
      load_data_o = shifted;
      case (funct3_i)
         F3_B:    load_data_o = {{24{shifted[7]}}, shifted[7:0]};
         F3_BU:   load_data_o = {24'h000000, shifted[7:0]};
         F3_H:    load_data_o = {{16{shifted[15]}}, shifted[15:0]};
         F3_HU:   load_data_o = {16'h0000, shifted[15:0]};
         default: load_data_o = shifted;
      endcase
   end

   // Replicate store data across all lanes so the mask alone picks the target lane.
   always_comb begin
      if (funct3_i[0]) begin
         lane_mask = 32'h0000_FFFF << shamt;
         lane_data = {2{wdata_i[15:0]}};
      end else begin
         lane_mask = 32'h0000_00FF << shamt;
         lane_data = {4{wdata_i[7:0]}};
      end
      merged_o = (rd_word_i & ~lane_mask) | (lane_data & lane_mask);
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single-cycle loads and word stores, read-modify-write for sub-word
// stores, and error responses for misaligned or illegal requests.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W = LSU_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              we,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              ready,
   output logic              done,
   output logic              err,
   output logic [31:0]       rdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_a,
   output logic [31:0]       mem_wd,
   input  logic [31:0]       mem_rd
);

   logic [1:0]        state_q, state_d;
   logic              err_q, err_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [31:0]       data_q, data_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   logic [ADDR_W-1:0] word_a;
   logic              illegal, misaligned, bad;
   logic [31:0]       load_data, merged;

   assign word_a     = {addr[ADDR_W-1:2], 2'b00};
   assign illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (we && funct3[2]);
   assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                       ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
   assign bad        = illegal || misaligned;

   lsu_align u_align (
      .funct3_i    (funct3),
      .offset_i    (addr[1:0]),
      .rd_word_i   (mem_rd),
      .wdata_i     (wdata),
      .load_data_o (load_data),
      .merged_o    (merged)
   );

   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      addr_d  = addr_q;
      data_d  = data_q;
      mem_we  = 1'b0;
      mem_a   = word_a;
      mem_wd  = wdata;
      case (state_q)
         StIdle: begin
            if (req) begin
               state_d = StResp;
               err_d   = bad;
               if (!bad) begin
                  if (!we) begin
                     rdata_d = load_data;
                  end else if (funct3 == F3_W) begin
                     mem_we = 1'b1;
                  end else begin
                     addr_d  = word_a;
                     data_d  = merged;
                     state_d = StRmw;
                  end
               end
            end
         end
         StRmw: begin
            mem_we  = 1'b1;
            mem_a   = addr_q;
            mem_wd  = data_q;
            state_d = StResp;
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         err_q   <= 1'b0;
         rdata_q <= 32'h0;
         data_q  <= 32'h0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
      end
   end

   assign ready = (state_q == StIdle);
   assign done  = (state_q == StResp);
   assign err   = done & err_q;
   assign rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-lane reference model of memory
// and of the architectural load result.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic        ready, done, err, mem_we;
   logic [31:0] rdata, mem_a, mem_wd, mem_rd;

   logic [31:0] mem [64];
   logic [31:0] ref_mem [64];
   logic [31:0] ref_rdata = 32'h0;
   int          wr_count = 0;
   logic        pre_we = 1'b0;
   logic [5:0]  pre_idx = 6'd0;
   logic [31:0] pre_data = 32'h0;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_W(32)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req),
      .we     (we),
      .funct3 (funct3),
      .addr   (addr),
      .wdata  (wdata),
      .ready  (ready),
      .done   (done),
      .err    (err),
      .rdata  (rdata),
      .mem_we (mem_we),
      .mem_a  (mem_a),
      .mem_wd (mem_wd),
      .mem_rd (mem_rd)
   );

   assign mem_rd = mem[mem_a[7:2]];

   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_a[7:2]] <= mem_wd;
         wr_count <= wr_count + 1;
      end else if (pre_we) begin
         mem[pre_idx] <= pre_data;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] word, input int off,
                                              input logic [2:0] f3);
      int unsigned b, h;
      b = (word >> (8 * off)) % 256;
      h = (word >> (8 * off)) % 65536;
      case (f3)
         3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         3'b100:  return b;
         3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         3'b101:  return h;
         default: return word;
      endcase
   endfunction

   function automatic logic [31:0] model_store(input logic [31:0] word, input int off,
                                               input logic [2:0] f3, input logic [31:0] wd);
      int unsigned sh, modv, old;
      if (f3 == 3'b010) return wd;
      sh   = 8 * off;
      modv = (f3 == 3'b000) ? 256 : 65536;
      old  = (word >> sh) % modv;
      return word - (old << sh) + ((wd % modv) << sh);
   endfunction

   function automatic bit model_err(input bit w, input logic [2:0] f3, input logic [31:0] a);
      int size;
      case (f3)
         3'b000, 3'b100: size = 1;
         3'b001, 3'b101: size = 2;
         3'b010:         size = 4;
         default:        return 1'b1;
      endcase
      if (w && size < 4 && f3[2]) return 1'b1;
      return (a % size) != 0;
   endfunction

   task automatic preload(input int idx, input logic [31:0] data);
      @(negedge clk);
      pre_we   = 1'b1;
      pre_idx  = idx[5:0];
      pre_data = data;
      @(posedge clk);
      #1;
      pre_we = 1'b0;
      ref_mem[idx] = data;
   endtask

   // One complete transaction; returns with the unit back in IDLE.
   task automatic do_access(input bit w, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd);
      int  idx, off, wc0;
      bit  exp_err, rmw, sw;
      idx     = int'(a[7:2]);
      off     = int'(a % 4);
      exp_err = model_err(w, f3, a);
      rmw     = !exp_err && w && (f3 != 3'b010);
      sw      = !exp_err && w && (f3 == 3'b010);
      if (!exp_err) begin
         if (w) ref_mem[idx] = model_store(ref_mem[idx], off, f3, wd);
         else   ref_rdata    = model_load(ref_mem[idx], off, f3);
      end
      @(negedge clk);
      check_eq("idle_ready", {31'h0, ready}, 32'h1);
      req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
      wc0 = wr_count;
      #1;
      check_eq("idle_mem_a", mem_a, a & 32'hFFFF_FFFC);
      check_eq("idle_mem_we", {31'h0, mem_we}, {31'h0, sw});
      @(posedge clk);
      #1;
      req = 1'b0;
      if (rmw) begin
         check_eq("rmw_mem_we", {31'h0, mem_we}, 32'h1);
         check_eq("rmw_done", {31'h0, done}, 32'h0);
         check_eq("rmw_ready", {31'h0, ready}, 32'h0);
         @(posedge clk);
         #1;
      end
      check_eq("resp_done", {31'h0, done}, 32'h1);
      check_eq("resp_err", {31'h0, err}, {31'h0, exp_err});
      check_eq("resp_rdata", rdata, ref_rdata);
      check_eq("resp_mem_we", {31'h0, mem_we}, 32'h0);
      @(posedge clk);
      #1;
      check_eq("after_done", {31'h0, done}, 32'h0);
      check_eq("after_err", {31'h0, err}, 32'h0);
      check_eq("write_count", wr_count - wc0, (w && !exp_err) ? 1 : 0);
      check_eq("mem_word", mem[idx], ref_mem[idx]);
   endtask

   initial begin
      int wc0;
      #1;
      check_eq("rst_ready", {31'h0, ready}, 32'h1);
      check_eq("rst_done", {31'h0, done}, 32'h0);
      check_eq("rst_err", {31'h0, err}, 32'h0);
      check_eq("rst_rdata", rdata, 32'h0);
      check_eq("rst_mem_we", {31'h0, mem_we}, 32'h0);
      for (int i = 0; i < 64; i++) preload(i, $urandom);
      preload(4, 32'h8899_AABB);
      @(negedge clk);
      rst_n = 1'b1;

      do_access(1'b0, F3_B, 32'h13, 32'h0);
      check_eq("lb_value", rdata, 32'hFFFF_FF88);
      do_access(1'b0, F3_BU, 32'h13, 32'h0);
      check_eq("lbu_value", rdata, 32'h0000_0088);
      do_access(1'b1, F3_B, 32'h11, 32'h0000_00CC);
      check_eq("sb_word", mem[4], 32'h8899_CCBB);
      preload(4, 32'h8899_AABB);
      do_access(1'b1, F3_H, 32'h12, 32'h0000_1234);
      check_eq("sh_word", mem[4], 32'h1234_AABB);
      do_access(1'b0, F3_HU, 32'h12, 32'h0);
      check_eq("lhu_value", rdata, 32'h0000_1234);
      do_access(1'b0, F3_W, 32'h06, 32'h0);
      check_eq("lw_mis_rdata", rdata, 32'h0000_1234);
      do_access(1'b1, F3_H, 32'h11, 32'hFFFF_FFFF);
      check_eq("sh_mis_word", mem[4], 32'h1234_AABB);

      // req held high through an SB, then retargeted to a load of the same byte.
      @(negedge clk);
      req = 1'b1; we = 1'b1; funct3 = F3_B; addr = 32'h11; wdata = 32'h5A;
      wc0 = wr_count;
      ref_mem[4] = model_store(ref_mem[4], 1, F3_B, 32'h5A);
      @(posedge clk); #1;
      check_eq("hold_rmw_ready", {31'h0, ready}, 32'h0);
      check_eq("hold_rmw_we", {31'h0, mem_we}, 32'h1);
      @(posedge clk); #1;
      check_eq("hold_resp_done", {31'h0, done}, 32'h1);
      check_eq("hold_resp_ready", {31'h0, ready}, 32'h0);
      we = 1'b0; funct3 = F3_BU;
      ref_rdata = model_load(ref_mem[4], 1, F3_BU);
      @(posedge clk); #1;
      check_eq("hold_idle_ready", {31'h0, ready}, 32'h1);
      check_eq("hold_idle_done", {31'h0, done}, 32'h0);
      @(posedge clk); #1;
      req = 1'b0;
      check_eq("hold_ld_done", {31'h0, done}, 32'h1);
      check_eq("hold_ld_rdata", rdata, ref_rdata);
      check_eq("hold_ld_lit", rdata, 32'h0000_005A);
      @(posedge clk); #1;
      check_eq("hold_no_dup", {31'h0, done}, 32'h0);
      check_eq("hold_writes", wr_count - wc0, 1);
      check_eq("hold_word", mem[4], ref_mem[4]);

      // Reset asserted while the RMW write is pending.
      @(negedge clk);
      req = 1'b1; we = 1'b1; funct3 = F3_B; addr = 32'h21; wdata = 32'h77;
      wc0 = wr_count;
      @(posedge clk); #1;
      req = 1'b0;
      check_eq("rst_rmw_we", {31'h0, mem_we}, 32'h1);
      rst_n = 1'b0;
      #1;
      check_eq("rst_drop_we", {31'h0, mem_we}, 32'h0);
      check_eq("rst_mid_ready", {31'h0, ready}, 32'h1);
      check_eq("rst_mid_done", {31'h0, done}, 32'h0);
      check_eq("rst_mid_rdata", rdata, 32'h0);
      ref_rdata = 32'h0;
      @(posedge clk); #1;
      check_eq("rst_mem_kept", mem[8], ref_mem[8]);
      check_eq("rst_no_write", wr_count - wc0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("rst_rel_ready", {31'h0, ready}, 32'h1);

      for (int i = 0; i < 200; i++) begin
         do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   32'($urandom_range(0, 255)), $urandom);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
